// File: rtl/program_loader.sv
// Framed byte-stream boot loader: header, length, payload (and optional
// XOR checksum when LOADER_CHECKSUM_EN is defined) written into CPU memory.
module program_loader #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_load,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TO_LAST);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     cnt_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [1:0]          err_d;
  logic                xfer;
  logic                len_bad;
  logic                last_byte;
  logic                timeout_hit;
  logic                restart;
  logic [31:0]         n_ext;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q;
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = err_code;
    byte_ready = 1'b0;
    restart    = 1'b0;
    n_ext      = 32'(byte_in);
    len_bad    = (n_ext == 32'd0) || (n_ext > (32'd1 << ADDR_W));
    last_byte  = ((cnt_q + (ADDR_W + 1)'(1)) == len_q);

    case (state_q)
      HDR, LEN, DATA: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CSUM:           byte_ready = 1'b1;
`endif
      default:        byte_ready = 1'b0;
    endcase

    xfer        = byte_ready && byte_valid;
    timeout_hit = (TIMEOUT != 0) && byte_ready && !byte_valid && (idle_q == IDLE_LAST);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          err_d   = 2'b00;
          restart = 1'b1;
        end
      end
      HDR: if (xfer) state_d = LEN;
      LEN: begin
        if (xfer) begin
          if (len_bad) begin
            state_d = ERR;
            err_d   = 2'b01;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          if (byte_in == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
            err_d   = 2'b10;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // a stall can only expire while no byte is moving, so it never races a transition
    if (timeout_hit) begin
      state_d = ERR;
      err_d   = 2'b11;
    end

    done     = (state_q == DONE);
    cpu_load = (state_q != DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_code   <= 2'b00;
      load_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      err_code <= err_d;
      mem_we   <= 1'b0;

      if (!byte_ready || xfer) idle_q <= '0;
      else                     idle_q <= idle_q + IDLE_W'(1);

      if (restart) begin
        cnt_q      <= '0;
        load_count <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end

      if (xfer) begin
        case (state_q)
          HDR: base_q <= byte_in[ADDR_W-1:0];
          LEN: len_q  <= byte_in[ADDR_W:0];
          DATA: begin
            mem_we     <= 1'b1;
            mem_addr   <= base_q + cnt_q[ADDR_W-1:0];
            mem_wdata  <= byte_in;
            cnt_q      <= cnt_q + (ADDR_W + 1)'(1);
            load_count <= cnt_q + (ADDR_W + 1)'(1);
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ byte_in;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
